// File: rtl/div_seq.sv
// rtl/div_seq.sv - iterative radix-2 restoring divider with sequencer for DIV/DIVU
// Optional macro DIV_SMALL_BYPASS_EN: short-circuit |opa| < |opb| straight to DONE.
module div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 signed_div,
  input  logic [WIDTH-1:0]     opa,
  input  logic [WIDTH-1:0]     opb,
  input  logic                 cancel,
  output logic                 stall_div,
  output logic                 ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     quo_q, quo_d;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]     rem_q, rem_d;     // partial remainder
  logic [WIDTH-1:0]     div_q, div_d;     // divisor magnitude
  logic                 negq_q, negq_d;   // quotient needs negation
  logic                 negr_q, negr_d;   // remainder needs negation
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       step_tmp;
  logic                 step_ge;
  logic [WIDTH-1:0]     step_rem, step_quo, fin_rem, fin_quo;

  // Datapath step, sign fix-up and next-state sequencing
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    div_d    = div_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;

    abs_a = (signed_div && opa[WIDTH-1]) ? -opa : opa;
    abs_b = (signed_div && opb[WIDTH-1]) ? -opb : opb;

    // The shifted remainder needs one extra bit; the difference always fits WIDTH bits,
    // so the subtraction can be done modulo 2^WIDTH.
    step_tmp = {rem_q, quo_q[WIDTH-1]};
    step_ge  = step_tmp >= {1'b0, div_q};
    step_rem = step_ge ? (step_tmp[WIDTH-1:0] - div_q) : step_tmp[WIDTH-1:0];
    step_quo = {quo_q[WIDTH-2:0], step_ge};
    fin_quo  = negq_q ? -step_quo : step_quo;
    fin_rem  = negr_q ? -step_rem : step_rem;

    if (cancel) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            div_d  = abs_b;
            quo_d  = abs_a;
            rem_d  = '0;
            cnt_d  = '0;
            negq_d = signed_div & (opa[WIDTH-1] ^ opb[WIDTH-1]);
            negr_d = signed_div & opa[WIDTH-1];
            if (opb == '0) begin
              // Divide by zero: raw dividend as remainder, all-ones quotient
              state_d  = S_DONE;
              result_d = {opa, {WIDTH{1'b1}}};
            end
`ifdef DIV_SMALL_BYPASS_EN
            else if (abs_a < abs_b) begin
              state_d  = S_DONE;
              result_d = {opa, {WIDTH{1'b0}}};
            end
`endif
            else begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          quo_d = step_quo;
          rem_d = step_rem;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = S_DONE;
            result_d = {fin_rem, fin_quo};
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  // Stall drops in DONE so the pipeline advances on the HI/LO capture edge
  assign stall_div = !cancel && (((state_q == S_IDLE) && start) || (state_q == S_RUN));
  assign ready     = !cancel && (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - self-checking bench for div_seq against an arithmetic reference model
module tb_div_seq;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        cancel;
  logic        stall_div;
  logic        ready;
  logic [63:0] result;
  logic        busy;

  int checks;
  int errors;
  int cyc;

  div_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .resetn(resetn), .start(start), .signed_div(signed_div),
    .opa(opa), .opb(opb), .cancel(cancel), .stall_div(stall_div),
    .ready(ready), .result(result), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer division, truncation toward zero, modulo 2^32
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic int exp_stalls(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    ma = (s && a[31]) ? -a : a;
    mb = (s && b[31]) ? -b : b;
    if (b == 32'd0) return 1;
`ifdef DIV_SMALL_BYPASS_EN
    if (ma < mb) return 1;
`else
    if (ma == 32'hDEAD_0000 && mb == 32'd0) return 0;
`endif
    return 33;
  endfunction

  // Drive one division starting at a negedge; returns at the negedge+1 where ready was seen
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b, input bit hold,
                         output logic [63:0] res, output int stalls, output bit got, output int t);
    start = 1'b1; signed_div = s; opa = a; opb = b;
    stalls = 0; got = 0; res = '0; t = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      #1;
      if (ready) begin
        got = 1; res = result; t = cyc;
      end else begin
        if (stall_div) stalls++;
        @(negedge clk);
      end
    end
    if (!hold) start = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0; start = 1'b0; cancel = 1'b0; signed_div = 1'b0; opa = '0; opb = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++; if (stall_div !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall_div); end
    checks++; if (result !== 64'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divu_basic;
    logic [63:0] r; int st; bit got; int t;
    run_div(1'b0, 32'd100, 32'd7, 1'b0, r, st, got, t);
    checks++; if (!got) begin errors++; $display("FAIL divu_timeout: no ready"); end
    checks++; if (r !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_100_7: got %h expected %h", r, {32'd2, 32'd14}); end
    checks++; if (st !== 33) begin errors++; $display("FAIL divu_stalls: got %0d expected 33", st); end
    @(negedge clk); #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ready_one_cycle: got %b expected 0", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_done: got %b expected 0", busy); end
  endtask

  task automatic test_signed;
    logic [31:0] ta [5] = '{32'hFFFF_FFF9, 32'd7,        32'h8000_0000, 32'd5,  32'hFFFF_FFFB};
    logic [31:0] tb [5] = '{32'd2,        32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0,  32'd0};
    logic        ts [5] = '{1'b1,         1'b1,         1'b1,          1'b0,   1'b1};
    logic [63:0] te [5] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'd1, 32'hFFFF_FFFD},
                           {32'd0, 32'h8000_0000}, {32'd5, 32'hFFFF_FFFF},
                           {32'hFFFF_FFFB, 32'hFFFF_FFFF}};
    int          tst [5] = '{33, 33, 33, 1, 1};
    logic [63:0] r; int st; bit got; int t;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      run_div(ts[i], ta[i], tb[i], 1'b0, r, st, got, t);
      checks++; if (!got || r !== te[i]) begin errors++; $display("FAIL directed_%0d: got %h expected %h", i, r, te[i]); end
      checks++; if (st !== tst[i]) begin errors++; $display("FAIL directed_stall_%0d: got %0d expected %0d", i, st, tst[i]); end
    end
  endtask

  task automatic test_cancel;
    logic [63:0] r; int st; bit got; int t; bit seen;
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; opa = 32'd12345; opb = 32'd17;
    repeat (11) @(negedge clk);
    cancel = 1'b1; start = 1'b0; #1;
    checks++; if (stall_div !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL cancel_comb: got stall=%b ready=%b expected 0 0", stall_div, ready); end
    @(negedge clk);
    cancel = 1'b0; #1;
    checks++; if (busy !== 1'b0 || stall_div !== 1'b0) begin errors++; $display("FAIL cancel_idle: got busy=%b stall=%b expected 0 0", busy, stall_div); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (ready) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL cancel_no_ready: got ready pulse expected none"); end
    run_div(1'b0, 32'd9, 32'd3, 1'b0, r, st, got, t);
    checks++; if (!got || r !== {32'd0, 32'd3}) begin errors++; $display("FAIL after_cancel: got %h expected %h", r, {32'd0, 32'd3}); end
    checks++; if (st !== 33) begin errors++; $display("FAIL after_cancel_stall: got %0d expected 33", st); end
  endtask

  task automatic test_async_reset;
    logic [63:0] r; int st; bit got; int t;
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; opa = 32'd1000; opb = 32'd3;
    repeat (21) @(negedge clk);
    #2; resetn = 1'b0; start = 1'b0; #1;
    checks++; if (busy !== 1'b0 || ready !== 1'b0 || stall_div !== 1'b0 || result !== 64'd0) begin
      errors++; $display("FAIL async_reset: got busy=%b ready=%b stall=%b result=%h expected all 0", busy, ready, stall_div, result);
    end
    @(negedge clk); resetn = 1'b1; @(negedge clk);
    run_div(1'b0, 32'd64, 32'd8, 1'b0, r, st, got, t);
    checks++; if (!got || r !== {32'd0, 32'd8}) begin errors++; $display("FAIL after_reset: got %h expected %h", r, {32'd0, 32'd8}); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] r1, r2; int st1, st2; bit g1, g2; int t1, t2;
    @(negedge clk);
    run_div(1'b0, 32'd20, 32'd6, 1'b1, r1, st1, g1, t1);
    @(negedge clk);
    run_div(1'b0, 32'd15, 32'd4, 1'b0, r2, st2, g2, t2);
    checks++; if (!g1 || r1 !== {32'd2, 32'd3}) begin errors++; $display("FAIL b2b_first: got %h expected %h", r1, {32'd2, 32'd3}); end
    checks++; if (!g2 || r2 !== {32'd3, 32'd3}) begin errors++; $display("FAIL b2b_second: got %h expected %h", r2, {32'd3, 32'd3}); end
    checks++; if (t2 - t1 !== 34) begin errors++; $display("FAIL b2b_spacing: got %0d expected 34", t2 - t1); end
  endtask

  task automatic test_small;
    logic [63:0] r; int st; bit got; int t;
    @(negedge clk);
    run_div(1'b0, 32'd3, 32'd9, 1'b0, r, st, got, t);
    checks++; if (!got || r !== {32'd3, 32'd0}) begin errors++; $display("FAIL small_3_9: got %h expected %h", r, {32'd3, 32'd0}); end
    checks++; if (st !== exp_stalls(1'b0, 32'd3, 32'd9)) begin errors++; $display("FAIL small_stall: got %0d expected %0d", st, exp_stalls(1'b0, 32'd3, 32'd9)); end
  endtask

  task automatic test_random;
    logic [63:0] r, e; int st; bit got; int t;
    logic s; logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = $urandom_range(1, 15);
        2: b = -($urandom_range(1, 15));
        3: b = a >> $urandom_range(0, 31);
        default: b = (i % 5 == 0) ? 32'd0 : $urandom_range(1, 1000);
      endcase
      if (i % 7 == 3) a = $urandom_range(0, 20);
      e = ref_div(s, a, b);
      @(negedge clk);
      run_div(s, a, b, 1'b0, r, st, got, t);
      checks++; if (!got || r !== e) begin errors++; $display("FAIL rand_%0d s=%b %h/%h: got %h expected %h", i, s, a, b, r, e); end
      checks++; if (st !== exp_stalls(s, a, b)) begin errors++; $display("FAIL rand_stall_%0d: got %0d expected %0d", i, st, exp_stalls(s, a, b)); end
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    test_reset;
    test_divu_basic;
    test_signed;
    test_cancel;
    test_async_reset;
    test_back_to_back;
    test_small;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
